// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue feeding the register file write port.
// ALU and load results are buffered here because a debug/CSR write may take the
// port in any cycle. Pending outputs let decode stall on queued, unwritten targets.
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_rd,
    input  logic [DATA_W-1:0]            alu_data,
    output logic                         alu_ready,
    input  logic                         lsu_valid,
    input  logic [ADDR_W-1:0]            lsu_rd,
    input  logic [DATA_W-1:0]            lsu_data,
    output logic                         lsu_ready,
    input  logic                         dbg_we,
    input  logic [ADDR_W-1:0]            dbg_rd,
    input  logic [DATA_W-1:0]            dbg_data,
    output logic [ADDR_W-1:0]            Rw,
    output logic                         RegWr,
    output logic [DATA_W-1:0]            busW,
    input  logic [ADDR_W-1:0]            q_rs1,
    input  logic [ADDR_W-1:0]            q_rs2,
    output logic                         rs1_pending,
    output logic                         rs2_pending,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              full;
    logic              fire;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_rd;
    logic [DATA_W-1:0] push_data;

    // Enqueue arbitration: the LSU always wins, the ALU only goes when the LSU is idle.
    // A fired result targeting x0 completes its handshake but is never stored.
    always_comb begin
        full      = (count == FULL_COUNT);
        lsu_ready = !full;
        alu_ready = !full && !lsu_valid;
        push_rd   = lsu_valid ? lsu_rd   : alu_rd;
        push_data = lsu_valid ? lsu_data : alu_data;
        fire      = (lsu_valid || alu_valid) && !full;
        push      = fire && (push_rd != '0);
        pop       = !dbg_we && (count != '0);
    end

    // Write port mux: debug owns the port; otherwise the queue head drains.
    always_comb begin
        RegWr = 1'b0;
        Rw    = '0;
        busW  = '0;
        if (dbg_we) begin
            RegWr = 1'b1;
            Rw    = dbg_rd;
            busW  = dbg_data;
        end else if (count != '0) begin
            RegWr = 1'b1;
            Rw    = ent_rd[rd_ptr];
            busW  = ent_data[rd_ptr];
        end
    end

    // Queue bookkeeping; push and pop never hit the same slot since push needs
    // not-full and pop needs not-empty, and both together imply distinct slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                ent_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                ent_valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= push_rd;
            ent_data[wr_ptr] <= push_data;
        end
    end

    // Hazard lookup over every occupied entry; x0 is never reported pending.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == q_rs1)) rs1_pending = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == q_rs2)) rs2_pending = 1'b1;
        end
        if (q_rs1 == '0) rs1_pending = 1'b0;
        if (q_rs2 == '0) rs2_pending = 1'b0;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scenario tasks plus a scoreboard of expected queued writes.
module tb_regfile_writeback;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        lsu_ready;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_rd = '0;
    logic [31:0] dbg_data = '0;
    logic [4:0]  Rw;
    logic        RegWr;
    logic [31:0] busW;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        rs1_pending;
    logic        rs2_pending;
    logic [2:0]  count;

    int  tests_run = 0;
    int  tests_failed = 0;
    wr_t sb[$];

    regfile_writeback #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .dbg_we(dbg_we), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
        .Rw(Rw), .RegWr(RegWr), .busW(busW),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .count(count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write seen on the port must be the debug write or the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && RegWr === 1'b1) begin
            tests_run++;
            if (dbg_we) begin
                if (Rw !== dbg_rd || busW !== dbg_data) begin
                    tests_failed++;
                    $display("[TB] FAIL dbg_write: got rd=%0d data=%h, want rd=%0d data=%h", Rw, busW, dbg_rd, dbg_data);
                end
            end else if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_write: got rd=%0d data=%h, want no write", Rw, busW);
            end else begin
                wr_t exp_w;
                exp_w = sb.pop_front();
                if (Rw !== exp_w.rd || busW !== exp_w.data) begin
                    tests_failed++;
                    $display("[TB] FAIL queued_write: got rd=%0d data=%h, want rd=%0d data=%h", Rw, busW, exp_w.rd, exp_w.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'd0 || count !== 3'd0 ||
            alu_ready !== 1'b1 || lsu_ready !== 1'b1 || rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got RegWr=%b Rw=%0d busW=%h count=%0d ardy=%b lrdy=%b p1=%b p2=%b, want 0 0 0 0 1 1 0 0",
                     RegWr, Rw, busW, count, alu_ready, lsu_ready, rs1_pending, rs2_pending);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        // Queue three loads while debug holds the port, then reset mid-cycle.
        dbg_we = 1'b1; dbg_rd = 5'd7; dbg_data = 32'h1;
        for (int i = 1; i <= 3; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(i); lsu_data = 32'hA0 + 32'(i);
            sb.push_back('{rd: 5'(i), data: 32'hA0 + 32'(i)});
            step();
        end
        lsu_valid = 1'b0;
        q_rs1 = 5'd2;
        #1;
        tests_run++;
        if (count !== 3'd3 || rs1_pending !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_fill: got count=%0d p1=%b, want count=3 p1=1", count, rs1_pending);
        end
        #1;
        rst = 1'b1; dbg_we = 1'b0;
        sb.delete();
        #1;
        tests_run++;
        if (RegWr !== 1'b0 || count !== 3'd0 || alu_ready !== 1'b1 || lsu_ready !== 1'b1 || rs1_pending !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got RegWr=%b count=%0d ardy=%b lrdy=%b p1=%b, want 0 0 1 1 0",
                     RegWr, count, alu_ready, lsu_ready, rs1_pending);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (RegWr !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_idle: got RegWr=%b in cycle %0d, want 0", RegWr, c);
            end
        end
        step();
    endtask

    task automatic test_single_alu();
        q_rs1 = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        sb.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (RegWr !== 1'b1 || rs1_pending !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_alu_issue: got RegWr=%b p1=%b, want 1 1", RegWr, rs1_pending);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (RegWr !== 1'b0 || rs1_pending !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_alu_retire: got RegWr=%b p1=%b, want 0 0", RegWr, rs1_pending);
        end
        step();
    endtask

    task automatic test_arbitration();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
        #1;
        tests_run++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL arb_ready: got lrdy=%b ardy=%b, want 1 0", lsu_ready, alu_ready);
        end
        sb.push_back('{rd: 5'd4, data: 32'h44});
        step();
        lsu_valid = 1'b0;
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL arb_alu_retry: got ardy=%b, want 1", alu_ready);
        end
        sb.push_back('{rd: 5'd3, data: 32'h33});
        step();
        alu_valid = 1'b0;
        for (int c = 0; c < 10 && sb.size() != 0; c++) step();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL arb_drain: got %0d writes outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_fill();
        int model_cnt;
        logic exp_ready;
        model_cnt = 0;
        dbg_we = 1'b1; dbg_rd = 5'd7; dbg_data = 32'h1;
        for (int i = 0; i < 6; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_data = 32'h100 + 32'(i);
            #1;
            exp_ready = (model_cnt != 4);
            tests_run++;
            if (lsu_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL fill_ready: got lrdy=%b at push %0d, want %b", lsu_ready, i, exp_ready);
            end
            if (exp_ready) begin
                sb.push_back('{rd: 5'(10 + i), data: 32'h100 + 32'(i)});
                model_cnt++;
            end
            step();
        end
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2;
        #1;
        tests_run++;
        if (count !== 3'd4 || lsu_ready !== 1'b0 || alu_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_full: got count=%0d lrdy=%b ardy=%b, want 4 0 0", count, lsu_ready, alu_ready);
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        dbg_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (RegWr !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL fill_drain_gap: got RegWr=%b at drain cycle %0d, want 1", RegWr, c);
            end
            step();
        end
        tests_run++;
        if (count !== 3'd0 || sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL fill_empty: got count=%0d outstanding=%0d, want 0 0", count, sb.size());
        end
    endtask

    task automatic test_x0();
        q_rs2 = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hABC;
        #1;
        tests_run++;
        if (lsu_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL x0_ready: got lrdy=%b, want 1", lsu_ready);
        end
        step();
        lsu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (count !== 3'd0 || RegWr !== 1'b0 || rs2_pending !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL x0_drop: got count=%0d RegWr=%b p2=%b, want 0 0 0", count, RegWr, rs2_pending);
        end
        step();
    endtask

    task automatic test_same_rd();
        q_rs1 = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h11;
        sb.push_back('{rd: 5'd9, data: 32'h11});
        step();
        alu_data = 32'h22;
        sb.push_back('{rd: 5'd9, data: 32'h22});
        @(negedge clk);
        tests_run++;
        if (rs1_pending !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL same_rd_pend_first: got p1=%b, want 1", rs1_pending);
        end
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rs1_pending !== 1'b1 || busW !== 32'h22) begin
            tests_failed++;
            $display("[TB] FAIL same_rd_second: got p1=%b busW=%h, want 1 00000022", rs1_pending, busW);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (rs1_pending !== 1'b0 || RegWr !== 1'b0 || sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL same_rd_retire: got p1=%b RegWr=%b outstanding=%0d, want 0 0 0", rs1_pending, RegWr, sb.size());
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  model_cnt;
        logic exp_ready;
        logic push_m;
        logic pop_m;
        model_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'($urandom_range(1, 31));
            alu_data  = $urandom;
            dbg_we    = ($urandom_range(0, 2) == 0);
            dbg_rd    = 5'($urandom_range(0, 31));
            dbg_data  = $urandom;
            #1;
            exp_ready = (model_cnt != 4);
            tests_run++;
            if (alu_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL b2b_ready: got ardy=%b at cycle %0d, want %b", alu_ready, i, exp_ready);
            end
            push_m = exp_ready;
            pop_m  = !dbg_we && (model_cnt != 0);
            if (push_m) sb.push_back('{rd: alu_rd, data: alu_data});
            model_cnt = model_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
            step();
        end
        alu_valid = 1'b0;
        dbg_we = 1'b0;
        for (int c = 0; c < 20 && sb.size() != 0; c++) step();
        tests_run++;
        if (sb.size() != 0 || count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drain: got outstanding=%0d count=%0d, want 0 0", sb.size(), count);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_alu();
        test_arbitration();
        test_fill();
        test_x0();
        test_same_rd();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
